synth_poly: RTL

SYNTH_POLY -- requirements
Module: synth_poly

---
 rtl/synth_poly.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/synth_poly.sv
// Polyphonic FM-style voice synthesizer: one voice per cycle,
// per-voice attack/release envelopes, saturated signed mix.
module synth_poly #(
  parameter int N_VOICES = 4,
  parameter int SAMPLE_W = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_VOICES*24-1:0]  carrier_fcws,
  input  logic [23:0]             mod_fcw,
  input  logic [4:0]              mod_shift,
  input  logic [N_VOICES-1:0]     note_en,
  input  logic                    wave_sel,
  input  logic [7:0]              attack_step,
  input  logic [7:0]              release_step,
  input  logic                    sample_req,
  output logic [SAMPLE_W-1:0]     sample,
  output logic                    sample_valid,
  output logic                    overrun
);

  localparam int ACC_W = SAMPLE_W + 4;
  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic signed [ACC_W-1:0] SMAX =
    ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [SAMPLE_W-1:0]       sample_q, sample_d;
  logic                      valid_q, valid_d;
  logic                      overrun_q, overrun_d;
  logic [23:0]               mod_ph_q [N_VOICES];
  logic [23:0]               mod_ph_d [N_VOICES];
  logic [23:0]               car_ph_q [N_VOICES];
  logic [23:0]               car_ph_d [N_VOICES];
  logic [7:0]                env_q [N_VOICES];
  logic [7:0]                env_d [N_VOICES];
  logic [23:0]               fcw_arr [N_VOICES];

  logic [23:0]               cur_mod, cur_car, cur_fcw;
  logic [7:0]                cur_env, env_new;
  logic                      cur_en, retrig, held;
  logic [8:0]                env_sum;
  logic [23:0]               mod_new, car_new, m_ext, m_sh;
  logic signed [14:0]        m, w;
  logic signed [23:0]        prod;
  logic signed [ACC_W-1:0]   contrib, acc_nx;
  logic [SAMPLE_W-1:0]       sat;

  always_comb begin
    for (int v = 0; v < N_VOICES; v++) begin
      fcw_arr[v] = carrier_fcws[24*v +: 24];
    end
  end

  // Datapath for the voice currently addressed by idx_q.
  always_comb begin
    cur_mod = mod_ph_q[idx_q];
    cur_car = car_ph_q[idx_q];
    cur_env = env_q[idx_q];
    cur_fcw = fcw_arr[idx_q];
    cur_en  = note_en[idx_q];
    retrig  = cur_en && (cur_env == 8'd0);
    held    = !cur_en && (cur_env == 8'd0);
    env_sum = {1'b0, cur_env} + {1'b0, attack_step};
    if (cur_en) begin
      env_new = env_sum[8] ? 8'd255 : env_sum[7:0];
    end else begin
      env_new = (cur_env > release_step) ?
                (cur_env - release_step) : 8'd0;
    end
    mod_new = (retrig ? 24'd0 : cur_mod) + mod_fcw;
    m       = $signed({1'b0, mod_new[23:10]}) - 15'sd8192;
    m_ext   = {{9{m[14]}}, m};
    m_sh    = m_ext << mod_shift;
    car_new = (retrig ? 24'd0 : cur_car) + cur_fcw + m_sh;
    if (wave_sel) begin
      w = car_new[23] ? -15'sd8192 : 15'sd8191;
    end else begin
      w = $signed({1'b0, car_new[23:10]}) - 15'sd8192;
    end
    prod    = 24'(w) * 24'($signed({1'b0, env_new}));
    contrib = held ? '0 : ACC_W'(prod >>> 8);
    acc_nx  = acc_q + contrib;
    if (acc_nx > SMAX) begin
      sat = SMAX[SAMPLE_W-1:0];
    end else if (acc_nx < SMIN) begin
      sat = SMIN[SAMPLE_W-1:0];
    end else begin
      sat = acc_nx[SAMPLE_W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (sample_req && (state_q != S_IDLE));
    mod_ph_d  = mod_ph_q;
    car_ph_d  = car_ph_q;
    env_d     = env_q;
    unique case (state_q)
      S_IDLE: begin
        if (sample_req) begin
          state_d = S_COMPUTE;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_COMPUTE: begin
        env_d[idx_q] = env_new;
        if (!held) begin
          mod_ph_d[idx_q] = mod_new;
          car_ph_d[idx_q] = car_new;
        end
        acc_d = acc_nx;
        // Result is registered on the last voice so it is visible in DONE.
        if (idx_q == IDX_W'(N_VOICES - 1)) begin
          state_d  = S_DONE;
          sample_d = sat;
          valid_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int v = 0; v < N_VOICES; v++) begin
        mod_ph_q[v] <= '0;
        car_ph_q[v] <= '0;
        env_q[v]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      mod_ph_q  <= mod_ph_d;
      car_ph_q  <= car_ph_d;
      env_q     <= env_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule
